// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC sample path: buffer state encoding,
// midscale constant, offset-binary conversion and lane extraction.
package dac_pkg;

  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_SAMPLE_W = 8;
  localparam int unsigned MAX_SAMPLE_W = 32;
  localparam int unsigned MAX_WORD_W   = 512;

  typedef enum logic {
    BUF_EMPTY  = 1'b0,
    BUF_ACTIVE = 1'b1
  } buf_state_t;

  function automatic logic [MAX_SAMPLE_W-1:0] midscale(input int unsigned width,
                                                       input bit          offset_bin);
    logic [MAX_SAMPLE_W-1:0] m;
    m = '0;
    if (offset_bin) m[width-1] = 1'b1;
    return m;
  endfunction

  // Two's complement to offset binary is a flip of the sample MSB.
  function automatic logic [MAX_SAMPLE_W-1:0] to_offset_bin(input logic [MAX_SAMPLE_W-1:0] x,
                                                            input int unsigned             width);
    logic [MAX_SAMPLE_W-1:0] r;
    r = x;
    r[width-1] = ~x[width-1];
    return r;
  endfunction

  function automatic logic [MAX_SAMPLE_W-1:0] lane_slice(input logic [MAX_WORD_W-1:0] word,
                                                         input int unsigned           idx,
                                                         input int unsigned           width);
    return MAX_SAMPLE_W'(word >> (idx * width));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dac_sample_serializer.sv
// Unpacks multi-lane DAC words into one sample per strobe, with optional
// offset-binary output, gapless word reload and underrun handling/statistics.
module dac_sample_serializer
  import dac_pkg::*;
#(
  parameter int unsigned LANES          = DEF_LANES,
  parameter int unsigned SAMPLE_W       = DEF_SAMPLE_W,
  parameter int unsigned OUT_OFFSET_BIN = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES*SAMPLE_W-1:0] in_data,
  input  logic [LANES-1:0]          in_cw,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sample_stb,
  input  logic                      underrun_hold,
  input  logic                      clr_count,
  output logic [SAMPLE_W-1:0]       dac_data,
  output logic                      dac_cw,
  output logic                      dac_valid,
  output logic                      underrun,
  output logic [CNT_W-1:0]          underrun_count
);

  localparam int unsigned WORD_W = LANES * SAMPLE_W;
  localparam int unsigned IDX_W  = $clog2(LANES);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W, OUT_OFFSET_BIN != 0));

  buf_state_t              state;
  logic [WORD_W-1:0]       buf_data;
  logic [LANES-1:0]        buf_cw;
  logic [IDX_W-1:0]        lane_idx;
  logic                    last_lane;
  logic                    accept;
  logic                    strobe_empty;
  logic [MAX_WORD_W-1:0]   word_ext;
  logic [MAX_SAMPLE_W-1:0] lane_raw;
  logic [SAMPLE_W-1:0]     cur_sample;

  assign last_lane    = (lane_idx == LAST_IDX);
  assign in_ready     = (state == BUF_EMPTY) || (sample_stb && last_lane);
  assign accept       = in_valid && in_ready;
  assign strobe_empty = sample_stb && (state == BUF_EMPTY);

  always_comb begin
    word_ext = '0;
    word_ext[WORD_W-1:0] = buf_data;
    lane_raw = lane_slice(word_ext, 32'(lane_idx), SAMPLE_W);
    if (OUT_OFFSET_BIN != 0) lane_raw = to_offset_bin(lane_raw, SAMPLE_W);
    cur_sample = SAMPLE_W'(lane_raw);
  end

  // A word accepted on the last-lane strobe overrides the drop to EMPTY,
  // which is what keeps back-to-back words bubble-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BUF_EMPTY;
      buf_data  <= '0;
      buf_cw    <= '0;
      lane_idx  <= '0;
      dac_data  <= MID;
      dac_cw    <= 1'b0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      dac_valid <= sample_stb;
      underrun  <= 1'b0;
      if (sample_stb) begin
        if (state == BUF_ACTIVE) begin
          dac_data <= cur_sample;
          dac_cw   <= buf_cw[lane_idx];
          if (last_lane) begin
            lane_idx <= '0;
            state    <= BUF_EMPTY;
          end else begin
            lane_idx <= lane_idx + IDX_W'(1);
          end
        end else begin
          underrun <= 1'b1;
          dac_cw   <= 1'b0;
          if (!underrun_hold) dac_data <= MID;
        end
      end
      if (accept) begin
        buf_data <= in_data;
        buf_cw   <= in_cw;
        lane_idx <= '0;
        state    <= BUF_ACTIVE;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_underrun_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (strobe_empty),
    .clr  (clr_count),
    .count(underrun_count)
  );

endmodule

// File: tb/tb_dac_sample_serializer.sv
// Directed bench: main instance (offset binary, 16-bit count) plus a
// pass-through instance with a 2-bit counter sharing the same stimulus.
module tb_dac_sample_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_cw;
  logic        in_valid;
  logic        sample_stb;
  logic        underrun_hold;
  logic        clr_count;

  logic        in_ready, dac_cw, dac_valid, underrun;
  logic [7:0]  dac_data;
  logic [15:0] underrun_count;

  logic        raw_ready, raw_cw, raw_valid, raw_underrun;
  logic [7:0]  raw_data;
  logic [1:0]  raw_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  dac_sample_serializer #(
    .LANES(4), .SAMPLE_W(8), .OUT_OFFSET_BIN(1), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_cw(in_cw),
    .in_valid(in_valid), .in_ready(in_ready), .sample_stb(sample_stb),
    .underrun_hold(underrun_hold), .clr_count(clr_count),
    .dac_data(dac_data), .dac_cw(dac_cw), .dac_valid(dac_valid),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  dac_sample_serializer #(
    .LANES(4), .SAMPLE_W(8), .OUT_OFFSET_BIN(0), .CNT_W(2)
  ) u_raw (
    .clk(clk), .reset(reset), .in_data(in_data), .in_cw(in_cw),
    .in_valid(in_valid), .in_ready(raw_ready), .sample_stb(sample_stb),
    .underrun_hold(underrun_hold), .clr_count(clr_count),
    .dac_data(raw_data), .dac_cw(raw_cw), .dac_valid(raw_valid),
    .underrun(raw_underrun), .underrun_count(raw_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_cw = '0; in_valid = 1'b0;
    sample_stb = 1'b0; underrun_hold = 1'b0; clr_count = 1'b0;
    exp_cnt = 0;
    #12;
    chk("rst_data",  32'(dac_data), 32'h80);
    chk("rst_cw",    32'(dac_cw), 32'h0);
    chk("rst_valid", 32'(dac_valid), 32'h0);
    chk("rst_unr",   32'(underrun), 32'h0);
    chk("rst_cnt",   32'(underrun_count), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_raw_data", 32'(raw_data), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // T1: single word, strobe held high
    in_data = 32'h03020100; in_cw = 4'b0001; in_valid = 1'b1;
    #1 chk("t1_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; sample_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_data",  32'(dac_data), 32'h80 + 32'(i));
      chk("t1_cw",    32'(dac_cw), (i == 0) ? 32'h1 : 32'h0);
      chk("t1_valid", 32'(dac_valid), 32'h1);
      chk("t1_unr",   32'(underrun), 32'h0);
      chk("t1_raw",   32'(raw_data), 32'(i));
    end
    sample_stb = 1'b0;
    tick();
    chk("t1_idle_valid", 32'(dac_valid), 32'h0);
    chk("t1_idle_data",  32'(dac_data), 32'h83);
    chk("t1_cnt",        32'(underrun_count), 32'h0);

    // T2: gapless ramp across four back-to-back words
    in_data = 32'h03020100; in_cw = '0; in_valid = 1'b1;
    tick();
    in_data = 32'h07060504; sample_stb = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1 chk("t2_ready", 32'(in_ready), (k % 4 == 3) ? 32'h1 : 32'h0);
      tick();
      chk("t2_data",  32'(dac_data), 32'h80 + 32'(k));
      chk("t2_valid", 32'(dac_valid), 32'h1);
      chk("t2_unr",   32'(underrun), 32'h0);
      if (k % 4 == 3) begin
        in_data  = in_data + 32'h04040404;
        in_valid = (k < 11);
      end
    end
    sample_stb = 1'b0;
    tick();
    chk("t2_cnt", 32'(underrun_count), 32'h0);

    // T3: underrun with midscale, then with hold
    for (int h = 0; h < 2; h++) begin
      underrun_hold = (h == 1);
      in_data = 32'h03020100; in_cw = 4'b1000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; sample_stb = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        chk("t3_valid", 32'(dac_valid), 32'h1);
        if (i < 4) begin
          chk("t3_data", 32'(dac_data), 32'h80 + 32'(i));
          chk("t3_cw",   32'(dac_cw), (i == 3) ? 32'h1 : 32'h0);
          chk("t3_unr",  32'(underrun), 32'h0);
        end else begin
          exp_cnt++;
          chk("t3_unr_data", 32'(dac_data), (h == 1) ? 32'h83 : 32'h80);
          chk("t3_unr_cw",   32'(dac_cw), 32'h0);
          chk("t3_unr",      32'(underrun), 32'h1);
        end
        chk("t3_cnt", 32'(underrun_count), 32'(exp_cnt));
      end
      sample_stb = 1'b0;
      tick();
      chk("t3_unr_clear", 32'(underrun), 32'h0);
    end
    underrun_hold = 1'b0;

    // T4: strobe every third cycle, in_valid toggled while not ready
    in_data = 32'h07060504; in_cw = '0; in_valid = 1'b1;
    tick();
    in_data = 32'h0B0A0908;
    for (int j = 0; j < 8; j++) begin
      sample_stb = 1'b1;
      #1 chk("t4_ready_stb", 32'(in_ready), (j % 4 == 3) ? 32'h1 : 32'h0);
      tick();
      sample_stb = 1'b0; in_valid = 1'b0;
      chk("t4_data",  32'(dac_data), 32'h84 + 32'(j));
      chk("t4_valid", 32'(dac_valid), 32'h1);
      chk("t4_unr",   32'(underrun), 32'h0);
      #1 chk("t4_ready_idle", 32'(in_ready), (j == 7) ? 32'h1 : 32'h0);
      tick();
      chk("t4_hold1", 32'(dac_data), 32'h84 + 32'(j));
      chk("t4_gap1",  32'(dac_valid), 32'h0);
      in_valid = (j < 3);
      tick();
      chk("t4_hold2", 32'(dac_data), 32'h84 + 32'(j));
      chk("t4_gap2",  32'(dac_valid), 32'h0);
    end
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    exp_cnt++;
    chk("t4_extra_unr",  32'(underrun), 32'h1);
    chk("t4_extra_data", 32'(dac_data), 32'h80);
    chk("t4_cnt",        32'(underrun_count), 32'(exp_cnt));

    // T5: async reset mid-word
    in_data = 32'h13121110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; sample_stb = 1'b1;
    tick();
    chk("t5_l0", 32'(dac_data), 32'h90);
    tick();
    chk("t5_l1", 32'(dac_data), 32'h91);
    sample_stb = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    chk("t5_rst_data",  32'(dac_data), 32'h80);
    chk("t5_rst_valid", 32'(dac_valid), 32'h0);
    chk("t5_rst_cnt",   32'(underrun_count), 32'(exp_cnt));
    chk("t5_rst_raw",   32'(raw_data), 32'h0);
    tick();
    reset = 1'b0;
    in_data = 32'h23222120; in_valid = 1'b1;
    #1 chk("t5_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    chk("t5_new_l0",  32'(dac_data), 32'hA0);
    chk("t5_new_unr", 32'(underrun), 32'h0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();

    // T6: saturation of the 2-bit counter, clear beating increment
    sample_stb = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("t6_unr",     32'(underrun), 32'h1);
      chk("t6_cnt",     32'(underrun_count), 32'(n));
      chk("t6_sat_cnt", 32'(raw_count), (n > 3) ? 32'h3 : 32'(n));
    end
    clr_count = 1'b1;
    tick();
    chk("t6_clr_unr", 32'(underrun), 32'h1);
    chk("t6_clr_cnt", 32'(underrun_count), 32'h0);
    chk("t6_clr_sat", 32'(raw_count), 32'h0);
    clr_count = 1'b0;
    tick();
    chk("t6_after_clr", 32'(raw_count), 32'h1);
    sample_stb = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
